// File: rtl/commit_trace_pkg.sv
// Shared constants, FSM state type and entry packing for the commit trace buffer.
package commit_trace_pkg;

  localparam int ENTRY_W = 128;

  // Word selects within one 128-bit trace entry
  localparam logic [1:0] W_DATA_LO = 2'd0;
  localparam logic [1:0] W_DATA_HI = 2'd1;
  localparam logic [1:0] W_PC_LO   = 2'd2;
  localparam logic [1:0] W_META    = 2'd3;

  // Status register offsets (rd_addr[3:2] when rd_addr[31] is set)
  localparam logic [1:0] ST_COUNT   = 2'd0;
  localparam logic [1:0] ST_FLAGS   = 2'd1;
  localparam logic [1:0] ST_DROPPED = 2'd2;
  localparam logic [1:0] ST_DEPTH   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_ACK  = 2'd2
  } rd_state_t;

  function automatic logic [31:0] pack_meta(input logic       rf_wen,
                                            input logic [4:0] rf_dest,
                                            input logic [6:0] pc_hi);
    return {rf_wen, 19'b0, rf_dest, pc_hi};
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port, no reset.
module trace_ram
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // A read of the slot being written this cycle returns the previous contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures write-back commit records into a trace RAM and serves them, plus status,
// over a 4-phase req/ack word read port.
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int PC_W  = 39
) (
  input  logic            coreclk,
  input  logic            corerstn,
  input  logic            wbu_valid,
  input  logic [PC_W-1:0] wbu_pc,
  input  logic            wbu_rf_wen,
  input  logic [4:0]      wbu_rf_dest,
  input  logic [63:0]     wbu_rf_data,
  input  logic            cap_en,
  input  logic            ring_mode,
  input  logic            clr,
  input  logic            rd_req,
  input  logic [31:0]     rd_addr,
  output logic            rd_ack,
  output logic [31:0]     rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]      wr_ptr;
  logic [AW:0]        count;
  logic               overflow;
  logic [31:0]        dropped;
  logic               full, empty, capture, ram_we;
  logic [AW-1:0]      oldest, ram_raddr;
  logic [38:0]        pc_ext;
  logic [ENTRY_W-1:0] ram_wdata, ram_rdata;

  rd_state_t          state;
  logic               status_l;
  logic [1:0]         word_l;
  logic [AW-1:0]      idx_l;
  logic [AW:0]        count_l;
  logic [31:0]        rd_word;
  logic               unused_addr_bits;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign oldest  = wr_ptr - count[AW-1:0];
  assign capture = cap_en & wbu_valid & ~clr;
  assign ram_we  = capture & (~full | ring_mode);

  assign pc_ext    = 39'(wbu_pc);
  assign ram_wdata = {pack_meta(wbu_rf_wen, wbu_rf_dest, pc_ext[38:32]), pc_ext[31:0], wbu_rf_data};
  // RAM is addressed from the live request while idle so its output is ready in READ
  assign ram_raddr = oldest + rd_addr[AW+3:4];

  assign unused_addr_bits = ^{rd_addr[30:AW+4], rd_addr[1:0]};

  trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (coreclk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (ram_wdata),
    .re    (state == S_IDLE),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Capture pointers and status; clr wins over a same-cycle capture
  always_ff @(posedge coreclk) begin
    if (!corerstn || clr) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else if (capture) begin
      if (!full) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (ring_mode) begin
        wr_ptr   <= wr_ptr + 1'b1;
        overflow <= 1'b1;
      end else begin
        overflow <= 1'b1;
        if (dropped != 32'hFFFF_FFFF) dropped <= dropped + 1'b1;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (status_l) begin
      case (word_l)
        ST_COUNT:   rd_word = 32'(count);
        ST_FLAGS:   rd_word = {29'b0, overflow, full, empty};
        ST_DROPPED: rd_word = dropped;
        default:    rd_word = 32'(DEPTH);
      endcase
    end else if ({1'b0, idx_l} < count_l) begin
      case (word_l)
        W_DATA_LO: rd_word = ram_rdata[31:0];
        W_DATA_HI: rd_word = ram_rdata[63:32];
        W_PC_LO:   rd_word = ram_rdata[95:64];
        default:   rd_word = ram_rdata[127:96];
      endcase
    end
  end

  // Read handshake FSM: IDLE -> READ -> ACK -> IDLE
  always_ff @(posedge coreclk) begin
    if (!corerstn) begin
      state   <= S_IDLE;
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (rd_req) begin
          state    <= S_READ;
          status_l <= rd_addr[31];
          word_l   <= rd_addr[3:2];
          idx_l    <= rd_addr[AW+3:4];
          count_l  <= count;
        end
        S_READ: begin
          state   <= S_ACK;
          rd_ack  <= 1'b1;
          rd_data <= rd_word;
        end
        S_ACK: if (!rd_req) begin
          state  <= S_IDLE;
          rd_ack <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with DEPTH=16: table-driven reads plus corner sequences.
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;
  localparam int PC_W  = 39;

  logic            clk = 1'b0;
  logic            corerstn;
  logic            wbu_valid;
  logic [PC_W-1:0] wbu_pc;
  logic            wbu_rf_wen;
  logic [4:0]      wbu_rf_dest;
  logic [63:0]     wbu_rf_data;
  logic            cap_en, ring_mode, clr, rd_req;
  logic [31:0]     rd_addr;
  logic            rd_ack;
  logic [31:0]     rd_data;

  int tests = 0;
  int fails = 0;

  commit_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .coreclk     (clk),
    .corerstn    (corerstn),
    .wbu_valid   (wbu_valid),
    .wbu_pc      (wbu_pc),
    .wbu_rf_wen  (wbu_rf_wen),
    .wbu_rf_dest (wbu_rf_dest),
    .wbu_rf_data (wbu_rf_data),
    .cap_en      (cap_en),
    .ring_mode   (ring_mode),
    .clr         (clr),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
    string       name;
  } rd_vec_t;

  rd_vec_t vecs [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge
  task automatic commit(input logic [PC_W-1:0] pc, input logic wen, input logic [4:0] dest,
                        input logic [63:0] data);
    wbu_valid = 1'b1; wbu_pc = pc; wbu_rf_wen = wen; wbu_rf_dest = dest; wbu_rf_data = data;
    @(negedge clk);
    wbu_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    rd_addr = a;
    rd_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_ack && n < 20);
    if (!rd_ack) begin
      tests++;
      fails++;
      $display("FAIL read_timeout: addr 0x%08h got no ack, expected ack within 20 cycles", a);
    end
    d = rd_data;
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_check(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    do_read(a, d);
    check(nm, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic        ack_seen;
    int          n;

    vecs[0]  = '{32'h8000_0000, 32'd3,          "t1_count"};
    vecs[1]  = '{32'h8000_0004, 32'h0,          "t1_status"};
    vecs[2]  = '{32'h0000_0028, 32'h8000_0008,  "t1_e2_pc"};
    vecs[3]  = '{32'h4000_0028, 32'h8000_0008,  "t1_e2_pc_ignbits"};
    vecs[4]  = '{32'h0000_0000, 32'hC000_0000,  "t1_e0_data_lo"};
    vecs[5]  = '{32'h0000_0014, 32'hD000_0001,  "t1_e1_data_hi"};
    vecs[6]  = '{32'h0000_001C, 32'h8000_0100,  "t1_e1_meta"};
    vecs[7]  = '{32'h0000_0030, 32'h0,          "t1_idx_eq_count"};
    vecs[8]  = '{32'h8000_0008, 32'h0,          "t1_dropped"};
    vecs[9]  = '{32'h8000_000C, 32'd16,         "t1_depth"};
    vecs[10] = '{32'hFFFF_FFF0, 32'd3,          "t1_count_ignbits"};

    corerstn = 1'b0; wbu_valid = 1'b0; wbu_pc = '0; wbu_rf_wen = 1'b0; wbu_rf_dest = '0;
    wbu_rf_data = '0; cap_en = 1'b0; ring_mode = 1'b0; clr = 1'b0; rd_req = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_rd_ack", {31'b0, rd_ack}, 32'h0);
    check("reset_rd_data", rd_data, 32'h0);
    corerstn = 1'b1;
    @(negedge clk);

    read_check("reset_status", 32'h8000_0004, 32'h1);
    read_check("reset_count", 32'h8000_0000, 32'h0);

    // Test 1: three commits, table-driven reads
    cap_en = 1'b1;
    for (int i = 0; i < 3; i++)
      commit(39'h80000000 + 39'(4 * i), 1'b1, 5'(i + 1),
             {32'hD000_0000 + 32'(i), 32'hC000_0000 + 32'(i)});
    cap_en = 1'b0;
    for (int i = 0; i < 11; i++) read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);

    // Test 2: ring mode wrap
    pulse_clr();
    ring_mode = 1'b1; cap_en = 1'b1;
    for (int i = 0; i < 20; i++) commit(39'(4 * i), 1'b0, 5'd0, 64'(i));
    cap_en = 1'b0;
    read_check("t2_count", 32'h8000_0000, 32'd16);
    read_check("t2_status", 32'h8000_0004, 32'h6);
    read_check("t2_e0_pc", 32'h0000_0008, 32'h10);
    read_check("t2_e15_pc", 32'h0000_00F8, 32'h4C);
    read_check("t2_dropped", 32'h8000_0008, 32'h0);

    // Test 3: stop-when-full mode
    pulse_clr();
    read_check("t3_status_after_clr", 32'h8000_0004, 32'h1);
    ring_mode = 1'b0; cap_en = 1'b1;
    for (int i = 0; i < 20; i++) commit(39'(4 * i), 1'b0, 5'd0, 64'(i));
    cap_en = 1'b0;
    read_check("t3_count", 32'h8000_0000, 32'd16);
    read_check("t3_dropped", 32'h8000_0008, 32'd4);
    read_check("t3_e15_pc", 32'h0000_00F8, 32'h3C);
    read_check("t3_e0_pc", 32'h0000_0008, 32'h0);
    read_check("t3_status", 32'h8000_0004, 32'h6);

    // Test 4: clr beats a same-cycle capture
    cap_en = 1'b1; clr = 1'b1; wbu_valid = 1'b1; wbu_pc = 39'h123;
    @(negedge clk);
    clr = 1'b0; wbu_valid = 1'b0; cap_en = 1'b0;
    read_check("t4_count", 32'h8000_0000, 32'h0);
    read_check("t4_dropped", 32'h8000_0008, 32'h0);
    read_check("t4_status", 32'h8000_0004, 32'h1);

    // Test 5: idx == count returns zero, meta word packing
    cap_en = 1'b1;
    commit(39'h7F_0000_0004, 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF);
    cap_en = 1'b0;
    read_check("t5_idx_eq_count", 32'h0000_0010, 32'h0);
    read_check("t5_meta", 32'h0000_000C, 32'h8000_02FF);
    read_check("t5_pc_lo", 32'h0000_0008, 32'h0000_0004);
    read_check("t5_data_hi", 32'h0000_0004, 32'h0123_4567);

    // Test 6: hold rd_req for 10 cycles
    rd_addr = 32'h8000_000C;
    rd_req  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("t6_ack_cycle%0d", k), {31'b0, rd_ack}, (k >= 2) ? 32'h1 : 32'h0);
    end
    check("t6_data", rd_data, 32'd16);
    rd_req  = 1'b0;
    rd_addr = 32'h8000_0000;
    @(negedge clk);
    check("t6_ack_drop", {31'b0, rd_ack}, 32'h0);
    @(negedge clk);
    check("t6_data_hold", rd_data, 32'd16);

    // Reset while in ACK
    rd_addr = 32'h8000_0000;
    rd_req  = 1'b1;
    ack_seen = 1'b0;
    n = 0;
    while (!ack_seen && n < 20) begin
      @(negedge clk);
      ack_seen = rd_ack;
      n++;
    end
    check("t6_ack_before_reset", {31'b0, ack_seen}, 32'h1);
    check("t6_count_before_reset", rd_data, 32'h1);
    corerstn = 1'b0;
    @(negedge clk);
    check("t6_reset_ack", {31'b0, rd_ack}, 32'h0);
    check("t6_reset_data", rd_data, 32'h0);
    rd_req   = 1'b0;
    corerstn = 1'b1;
    @(negedge clk);
    do_read(32'h8000_0000, d);
    check("t6_count_after_reset", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
